// File: rtl/light_controller.sv
// Push-button light sequencer: synchroniser, debounce, short/long press
// classification and an OFF/ON/BLINK mode machine driving the onboard LED.
//
// state   | meaning
// S_OFF   | LED dark, waiting for a press
// S_ON    | LED lit, optional auto-off timer running
// S_BLINK | LED toggles every BLINK_HALF cycles, lit phase first
module light_controller #(
    parameter int DEBOUNCE_CYCLES = 160000,
    parameter int LONG_CYCLES     = 16000000,
    parameter int TIMEOUT_CYCLES  = 0,
    parameter int BLINK_HALF      = 4000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PIN_1,
    output logic       LED,
    output logic       USBPU,
    output logic [1:0] STATE,
    output logic       PRESS_SHORT,
    output logic       PRESS_LONG
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int BW = $clog2(BLINK_HALF + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYCLES);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_ON    = 2'b01,
        S_BLINK = 2'b10
    } mode_t;

    mode_t           state_q, state_d;
    logic            sync_q, pin_s;
    logic            db_level, db_prev, db_fall;
    logic [DW-1:0]   stable_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            long_done;
    logic [TW-1:0]   tmo_cnt;
    logic            timeout;
    logic [BW-1:0]   blink_cnt;
    logic            phase;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 1'b0;
            pin_s  <= 1'b0;
        end else begin
            sync_q <= PIN_1;
            pin_s  <= sync_q;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_level   <= 1'b0;
            db_prev    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            db_prev <= db_level;
            if (pin_s == db_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
                db_level   <= ~db_level;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + DW'(1);
            end
        end
    end

    assign db_fall = db_prev & ~db_level;

    // Hold counter sits at zero while released, so each press starts from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            if (!db_level) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
            if (PRESS_LONG) begin
                long_done <= 1'b1;
            end else if (db_fall) begin
                long_done <= 1'b0;
            end
        end
    end

    assign PRESS_LONG  = db_level & (hold_cnt == HOLD_LAST);
    assign PRESS_SHORT = db_fall & ~long_done;
    assign timeout     = (TIMEOUT_CYCLES != 0) && (state_q == S_ON) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Press events outrank the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (PRESS_SHORT)     state_d = S_ON;
                else if (PRESS_LONG) state_d = S_BLINK;
            end
            S_ON: begin
                if (PRESS_SHORT)     state_d = S_OFF;
                else if (PRESS_LONG) state_d = S_BLINK;
                else if (timeout)    state_d = S_OFF;
            end
            S_BLINK: begin
                if (PRESS_SHORT)     state_d = S_OFF;
                else if (PRESS_LONG) state_d = S_ON;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if ((TIMEOUT_CYCLES != 0) && (state_q == S_ON) && (state_d == S_ON)
                     && !PRESS_SHORT && !PRESS_LONG) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (state_q != S_BLINK) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED <= 1'b0;
        end else begin
            LED <= (state_q == S_ON) | ((state_q == S_BLINK) & phase);
        end
    end

    assign STATE = state_q;
    assign USBPU = 1'b0;

endmodule

// File: tb/tb_light_controller.sv
// Bench for light_controller: directed scenarios plus random presses, all
// compared cycle by cycle against a behavioural model of the button/mode rules.
module tb_light_controller;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int TMO = 50;
    localparam int BH  = 5;
    localparam int HN  = 16384;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PIN_1 = 1'b0;
    logic       LED, USBPU, PRESS_SHORT, PRESS_LONG;
    logic [1:0] STATE;

    light_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .TIMEOUT_CYCLES (TMO),
        .BLINK_HALF     (BH)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PIN_1      (PIN_1),
        .LED        (LED),
        .USBPU      (USBPU),
        .STATE      (STATE),
        .PRESS_SHORT(PRESS_SHORT),
        .PRESS_LONG (PRESS_LONG)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [1:0] st_h [HN];
    logic       led_h[HN];
    logic       sh_h [HN];
    logic       lg_h [HN];

    // Behavioural model: ages in cycles instead of counters, phase by division.
    int m_s0, m_s1, m_db, m_run, m_age, m_long_seen, m_fell, m_fell_long;
    int m_mode, m_on_age, m_bl_age, m_led;
    int ev_s, ev_l, tmo_f, nxt, old_db;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_s0 = 0; m_s1 = 0; m_db = 0; m_run = 0; m_age = 0;
            m_long_seen = 0; m_fell = 0; m_fell_long = 0;
            m_mode = 0; m_on_age = 0; m_bl_age = 0; m_led = 0;
        end else begin
            ev_s  = (m_fell != 0 && m_fell_long == 0) ? 1 : 0;
            ev_l  = (m_db != 0 && m_age == LNG - 1) ? 1 : 0;
            tmo_f = (TMO != 0 && m_mode == 1 && m_on_age == TMO - 1) ? 1 : 0;
            nxt = m_mode;
            if (ev_s != 0)       nxt = (m_mode == 0) ? 1 : 0;
            else if (ev_l != 0)  nxt = (m_mode == 2) ? 1 : 2;
            else if (tmo_f != 0) nxt = 0;
            m_led = (m_mode == 1 || (m_mode == 2 && ((m_bl_age / BH) % 2) == 0)) ? 1 : 0;
            m_on_age = (m_mode == 1 && nxt == 1 && ev_s == 0 && ev_l == 0) ? m_on_age + 1 : 0;
            m_bl_age = (m_mode == 2 && nxt == 2) ? m_bl_age + 1 : 0;
            m_mode = nxt;

            old_db = m_db;
            if (m_s1 != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_run = 0;
                    m_db = (m_db != 0) ? 0 : 1;
                end
            end else begin
                m_run = 0;
            end
            if (old_db != 0 && m_db != 0) begin
                m_age++;
                if (ev_l != 0) m_long_seen = 1;
            end else if (old_db == 0 && m_db != 0) begin
                m_age = 0;
            end
            m_fell = (old_db != 0 && m_db == 0) ? 1 : 0;
            if (m_fell != 0) begin
                m_fell_long = (m_long_seen != 0 || ev_l != 0) ? 1 : 0;
                m_long_seen = 0;
            end
            m_s1 = m_s0;
            m_s0 = int'(PIN_1);
        end
    end

    always @(negedge CLK) begin
        if (cyc < HN) begin
            st_h[cyc]  = STATE;
            led_h[cyc] = LED;
            sh_h[cyc]  = PRESS_SHORT;
            lg_h[cyc]  = PRESS_LONG;
        end
        if (RST_N === 1'b1) begin
            check_eq("cyc_state", STATE, m_mode);
            check_eq("cyc_led", LED, m_led);
            check_eq("cyc_short", PRESS_SHORT, (m_fell != 0 && m_fell_long == 0) ? 1 : 0);
            check_eq("cyc_long", PRESS_LONG, (m_db != 0 && m_age == LNG - 1) ? 1 : 0);
            check_eq("cyc_usbpu", USBPU, 0);
        end
    end

    function automatic int count_pulses(input int is_long, input int a, input int b);
        int n = 0;
        for (int c = a; c < b && c < HN; c++) begin
            if (is_long != 0 ? lg_h[c] : sh_h[c]) n++;
        end
        return n;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input int h);
        PIN_1 = 1'b1;
        wait_cycles(h);
        PIN_1 = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (STATE == s) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_eq(tag, STATE, s);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    int t0, e, p, r, g, kind;

    initial begin
        RST_N = 1'b0;
        PIN_1 = 1'b0;
        wait_cycles(3);
        check_eq("rst_state", STATE, 0);
        check_eq("rst_led", LED, 0);
        check_eq("rst_usbpu", USBPU, 0);
        check_eq("rst_short", PRESS_SHORT, 0);
        check_eq("rst_long", PRESS_LONG, 0);
        #2 RST_N = 1'b1;
        @(negedge CLK);

        // bounce bursts never stay put for DEB samples, then a clean short press
        t0 = cyc;
        for (int i = 0; i < 30; i += g) begin
            g = $urandom_range(1, 3);
            PIN_1 = ~PIN_1;
            wait_cycles(g);
        end
        PIN_1 = 1'b1;
        wait_cycles(10);
        PIN_1 = 1'b0;
        wait_cycles(12);
        check_eq("bounce_shorts", count_pulses(0, t0, cyc), 1);
        check_eq("bounce_longs", count_pulses(1, t0, cyc), 0);
        check_eq("bounce_state", STATE, 1);
        p = -1;
        for (int c = t0; c < cyc; c++) if (sh_h[c] && p < 0) p = c;
        if (p < 0) p = t0;
        check_eq("led_lag", {30'd0, led_h[p + 1], led_h[p + 2]}, 1);
        check_eq("state_after_pulse", {st_h[p], st_h[p + 1]}, 4'b0001);

        // idle in ON until auto-off
        e = p + 1;
        wait_state("wait_autooff", 2'd0, 100, r);
        check_eq("autooff_len", r - e, TMO);

        // long press from OFF
        wait_cycles(3);
        t0 = cyc;
        press(40);
        wait_cycles(12);
        check_eq("long1_count", count_pulses(1, t0, cyc), 1);
        check_eq("long1_at", lg_h[t0 + 2 + DEB + LNG - 1], 1);
        check_eq("long1_noshort", count_pulses(0, t0, cyc), 0);
        check_eq("long1_state", STATE, 2);
        p = t0 + 2 + DEB + LNG - 1;
        for (int i = 0; i < 20; i++)
            check_eq("blink_pattern", led_h[p + 2 + i], ((i / BH) % 2 == 0) ? 1 : 0);

        t0 = cyc;
        press(30);
        wait_cycles(12);
        check_eq("long2_count", count_pulses(1, t0, cyc), 1);
        check_eq("long2_state", STATE, 1);
        wait_state("wait_off2", 2'd0, 100, r);

        // short press at ON cycle 30 wins before the timeout
        wait_cycles(3);
        press(8);
        wait_state("wait_on3", 2'd1, 40, e);
        wait_cycles(16);
        press(8);
        wait_cycles(10);
        check_eq("press30_pulse", sh_h[e + 30], 1);
        check_eq("press30_states", {st_h[e + 30], st_h[e + 31]}, 4'b0100);

        // long press landing exactly on the timeout cycle
        wait_cycles(5);
        press(8);
        wait_state("wait_on4", 2'd1, 40, e);
        wait_cycles(24);
        press(40);
        wait_cycles(12);
        check_eq("coll_long_at", lg_h[e + TMO - 1], 1);
        check_eq("coll_states", {st_h[e + TMO - 1], st_h[e + TMO]}, 4'b0110);
        g = 0;
        for (int c = e; c <= e + TMO; c++) if (st_h[c] == 2'd0) g++;
        check_eq("coll_no_off", g, 0);
        check_eq("coll_state", STATE, 2);

        // asynchronous reset in the middle of BLINK
        wait_cycles(7);
        #2 RST_N = 1'b0;
        #1;
        check_eq("midrst_led", LED, 0);
        check_eq("midrst_state", STATE, 0);
        check_eq("midrst_usbpu", USBPU, 0);
        wait_cycles(2);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        t0 = cyc;
        wait_cycles(30);
        check_eq("postrst_shorts", count_pulses(0, t0, cyc), 0);
        check_eq("postrst_longs", count_pulses(1, t0, cyc), 0);
        check_eq("postrst_state", STATE, 0);

        // reset released with the button already held
        PIN_1 = 1'b1;
        #2 RST_N = 1'b0;
        wait_cycles(3);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        t0 = cyc;
        wait_cycles(11);
        r = cyc;
        PIN_1 = 1'b0;
        wait_cycles(12);
        check_eq("held_rst_shorts", count_pulses(0, t0, cyc), 1);
        check_eq("held_rst_pulse_at", sh_h[r + 2 + DEB], 1);
        check_eq("held_rst_longs", count_pulses(1, t0, cyc), 0);
        check_eq("held_rst_state", STATE, 1);

        // random presses, glitches and resets against the model
        for (int i = 0; i < 45; i++) begin
            wait_cycles($urandom_range(0, 60));
            kind = $urandom_range(0, 9);
            if (kind <= 2)      press($urandom_range(1, 3));
            else if (kind <= 5) press($urandom_range(5, 14));
            else if (kind <= 7) press($urandom_range(22, 45));
            else if (kind == 8) press($urandom_range(18, 21));
            else begin
                #2 RST_N = 1'b0;
                @(negedge CLK);
                #2 RST_N = 1'b1;
                @(negedge CLK);
            end
        end
        wait_cycles(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
